// File: rtl/mux_scan_pkg.sv
// Shared state encoding and mode constants for the scanning N:1 selector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_scan_pkg;

    // Controller states: IDLE serves direct mode; SCAN walks the channels; DRAIN waits for the last word.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_nto1_if.sv
// Bundles the channel inputs, controls and registered output handshake of mux_scan_nto1.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer throttles f/f_valid in scan mode.
// With MUX_SCAN_CH_MASK_EN defined an extra ch_mask field selects the channels visited by a scan.
interface mux_scan_nto1_if #(
    parameter int W  = 4,
    parameter int N  = 8,
    parameter int SW = $clog2(N)
);
    logic [N*W-1:0] w;
    logic           mode;
    logic [SW-1:0]  sel;
    logic           start;
    logic           out_ready;
`ifdef MUX_SCAN_CH_MASK_EN
    logic [N-1:0]   ch_mask;
`endif
    logic [W-1:0]   f;
    logic [SW-1:0]  f_ch;
    logic           f_valid;
    logic           busy;
    logic           done;

`ifdef MUX_SCAN_CH_MASK_EN
    modport master (
        output w, mode, sel, start, out_ready, ch_mask,
        input  f, f_ch, f_valid, busy, done
    );
    modport slave (
        input  w, mode, sel, start, out_ready, ch_mask,
        output f, f_ch, f_valid, busy, done
    );
`else
    modport master (
        output w, mode, sel, start, out_ready,
        input  f, f_ch, f_valid, busy, done
    );
    modport slave (
        input  w, mode, sel, start, out_ready,
        output f, f_ch, f_valid, busy, done
    );
`endif

endinterface

// File: rtl/mux_nto1_sel.sv
// Combinational W-bit N:1 slice selector; an index at or beyond N yields all zeros.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module mux_nto1_sel #(
    parameter int W  = 4,
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N*W-1:0] w,
    input  logic [SW-1:0]  idx,
    output logic [W-1:0]   y
);

    // Compare against every legal index so out-of-range values fall through to zero.
    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == SW'(i)) begin
                y = w[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_nto1.sv
// Parametrised N:1 selector with registered output: direct mux of sel, or a one-shot scan of all channels.
// Latency: 1 cycle sel->f in direct mode; channel i appears i+1 edges after start when never stalled.
// Backpressure: in scan mode f/f_ch/f_valid hold while f_valid && !out_ready; direct mode ignores out_ready.
// Build option MUX_SCAN_CH_MASK_EN adds ch_mask so a scan visits only the selected channels.
module mux_scan_nto1
    import mux_scan_pkg::*;
#(
    parameter int W  = 4,
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_nto1_if.slave bus
);

    state_t         state_q, state_d;
    logic [SW-1:0]  ch_q, ch_d;
    logic [W-1:0]   f_q, f_d;
    logic [SW-1:0]  f_ch_q, f_ch_d;
    logic           f_valid_q, f_valid_d;
    logic           done_q, done_d;

    logic [W-1:0]   sel_word;
    logic [W-1:0]   ch_word;
    logic           ld;
    logic           last_ch;
    logic [SW-1:0]  next_ch;
    logic [SW-1:0]  first_ch;

    mux_nto1_sel #(.W(W), .N(N), .SW(SW)) u_sel_mux (
        .w   (bus.w),
        .idx (bus.sel),
        .y   (sel_word)
    );

    mux_nto1_sel #(.W(W), .N(N), .SW(SW)) u_ch_mux (
        .w   (bus.w),
        .idx (ch_q),
        .y   (ch_word)
    );

    // A new word may be loaded when the output slot is empty or is being consumed this cycle.
    assign ld = !f_valid_q || bus.out_ready;

`ifdef MUX_SCAN_CH_MASK_EN
    logic [N-1:0]   mask_q, mask_d;
    logic [SW:0]    nxt_hit;
    logic [SW:0]    first_hit;

    // Returns {found, index} of the lowest set bit of m at position lo or above.
    function automatic logic [SW:0] find_set(input logic [N-1:0] m, input int lo);
        logic          found;
        logic [SW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && m[i] && (i >= lo)) begin
                found = 1'b1;
                idx   = i[SW-1:0];
            end
        end
        return {found, idx};
    endfunction

    assign nxt_hit   = find_set(mask_q, int'(ch_q) + 1);
    assign first_hit = find_set(bus.ch_mask, 0);
    assign last_ch   = !nxt_hit[SW];
    assign next_ch   = nxt_hit[SW-1:0];
    assign first_ch  = first_hit[SW-1:0];
`else
    assign last_ch   = (ch_q == SW'(N - 1));
    assign next_ch   = ch_q + SW'(1);
    assign first_ch  = '0;
`endif

    // Next-state and output-register decode; every register holds unless a branch says otherwise.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        f_d       = f_q;
        f_ch_d    = f_ch_q;
        f_valid_d = f_valid_q;
        done_d    = 1'b0;
`ifdef MUX_SCAN_CH_MASK_EN
        mask_d    = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.mode == MODE_DIRECT) begin
                    f_d       = sel_word;
                    f_ch_d    = bus.sel;
                    f_valid_d = 1'b1;
                end else begin
                    f_valid_d = 1'b0;
                    if (bus.start) begin
                        state_d = SCAN;
                        ch_d    = first_ch;
`ifdef MUX_SCAN_CH_MASK_EN
                        mask_d  = bus.ch_mask;
`endif
                    end
                end
            end
            SCAN: begin
`ifdef MUX_SCAN_CH_MASK_EN
                if (mask_q == '0) begin
                    // Nothing selected: finish immediately without emitting a word.
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else
`endif
                if (ld) begin
                    f_d       = ch_word;
                    f_ch_d    = ch_q;
                    f_valid_d = 1'b1;
                    if (last_ch) begin
                        state_d = DRAIN;
                    end else begin
                        ch_d = next_ch;
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    f_valid_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset even in the middle of a scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            f_q       <= '0;
            f_ch_q    <= '0;
            f_valid_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef MUX_SCAN_CH_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            f_q       <= f_d;
            f_ch_q    <= f_ch_d;
            f_valid_q <= f_valid_d;
            done_q    <= done_d;
`ifdef MUX_SCAN_CH_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign bus.f       = f_q;
    assign bus.f_ch    = f_ch_q;
    assign bus.f_valid = f_valid_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Self-checking bench for mux_scan_nto1: directed steps plus randomised scans against a queue-based model.
// Latency: checks 1-cycle direct path and back-to-back scan emission.
// Backpressure: drives out_ready constant, stalled and random; held words must not change.
module tb_mux_scan_nto1;
    import mux_scan_pkg::*;

    localparam int W  = 4;
    localparam int N  = 8;
    localparam int SW = 3;
    localparam int N5 = 5;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mux_scan_nto1_if #(.W(W), .N(N),  .SW(SW)) bus  ();
    mux_scan_nto1_if #(.W(W), .N(N5), .SW(SW)) bus5 ();

    mux_scan_nto1 #(.W(W), .N(N),  .SW(SW)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mux_scan_nto1 #(.W(W), .N(N5), .SW(SW)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel i of a packed word, computed arithmetically.
    function automatic logic [W-1:0] exp_word(input logic [31:0] wv, input int i);
        return W'((wv >> (W * i)) & 32'hF);
    endfunction

    // One scan: the model is the ordered list of channels still owed to the consumer.
    task automatic run_scan(input logic [N-1:0] msk, input int rdy_mode, input bit disturb, input string nm);
        int            q[$];
        int            nexp;
        int            cyc;
        int            stall;
        int            words;
        bit            fin;
        bit            acc;
        bit            last;
        bit            hold;
        logic [W-1:0]  hf;
        logic [SW-1:0] hc;
        stall = 0;
        words = 0;
        fin   = 1'b0;
        cyc   = 0;
        for (int i = 0; i < N; i++) if (msk[i]) q.push_back(i);
        nexp = q.size();
`ifdef MUX_SCAN_CH_MASK_EN
        bus.ch_mask = msk;
`endif
        bus.mode      = MODE_SCAN;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({nm, "_start_busy"}, bus.busy, 1);
        chk({nm, "_start_fvalid"}, bus.f_valid, 0);
        chk({nm, "_start_done"}, bus.done, 0);
        while (!fin && cyc < 200) begin
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.f_valid && bus.f_ch == 3'd2 && stall < 3) begin
                        bus.out_ready = 1'b0;
                        stall++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
            endcase
            if (disturb) begin
                bus.start = 1'($urandom);
                bus.mode  = 1'($urandom);
                bus.sel   = 3'($urandom);
            end
            acc  = bus.f_valid && bus.out_ready;
            last = 1'b0;
            if (acc) begin
                words++;
                chk({nm, "_word_owed"}, (q.size() != 0), 1);
                if (q.size() != 0) begin
                    chk({nm, "_word"}, bus.f, exp_word(bus.w, q[0]));
                    chk({nm, "_ch"}, bus.f_ch, q[0]);
                    void'(q.pop_front());
                    last = (q.size() == 0);
                end
            end
            if (nexp == 0 && cyc == 0) last = 1'b1;
            hold = bus.f_valid && !bus.out_ready;
            hf   = bus.f;
            hc   = bus.f_ch;
            tick();
            cyc++;
            if (hold) begin
                chk({nm, "_hold_f"}, bus.f, hf);
                chk({nm, "_hold_ch"}, bus.f_ch, hc);
                chk({nm, "_hold_fvalid"}, bus.f_valid, 1);
            end
            if (rdy_mode == 0 && !last) chk({nm, "_stream_fvalid"}, bus.f_valid, 1);
            if (last) chk({nm, "_end_fvalid"}, bus.f_valid, 0);
            chk({nm, "_done"}, bus.done, last);
            chk({nm, "_busy"}, bus.busy, !last);
            fin = last;
        end
        chk({nm, "_completed"}, fin, 1);
        chk({nm, "_word_count"}, words, nexp);
        bus.start     = 1'b0;
        bus.mode      = MODE_SCAN;
        bus.sel       = '0;
        bus.out_ready = 1'b1;
        tick();
        chk({nm, "_after_done"}, bus.done, 0);
        chk({nm, "_after_busy"}, bus.busy, 0);
        chk({nm, "_after_fvalid"}, bus.f_valid, 0);
    endtask

    initial begin
        logic [31:0]   wv;
        logic [19:0]   wv5;
        logic [SW-1:0] s;
        logic [SW-1:0] s5;
        logic [N-1:0]  all_ch;
        logic [N-1:0]  rmsk;
        int            guard;
        n_tests = 0;
        n_fail  = 0;
        all_ch  = '1;

        rst_n          = 1'b1;
        bus.w          = 32'hFEDC_BA98;
        bus.mode       = MODE_DIRECT;
        bus.sel        = '0;
        bus.start      = 1'b0;
        bus.out_ready  = 1'b0;
        bus5.w         = '0;
        bus5.mode      = MODE_DIRECT;
        bus5.sel       = '0;
        bus5.start     = 1'b0;
        bus5.out_ready = 1'b0;
`ifdef MUX_SCAN_CH_MASK_EN
        bus.ch_mask    = '1;
        bus5.ch_mask   = '0;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("rst_f", bus.f, 0);
        chk("rst_fch", bus.f_ch, 0);
        chk("rst_fvalid", bus.f_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        tick();
        tick();
        chk("rst_held_fvalid", bus.f_valid, 0);
        rst_n = 1'b1;

        // Direct mode, directed.
        bus.sel = 3'd3;
        tick();
        chk("dir_sel3_f", bus.f, 4'hB);
        chk("dir_sel3_fch", bus.f_ch, 3);
        chk("dir_sel3_fvalid", bus.f_valid, 1);
        chk("dir_sel3_busy", bus.busy, 0);
        chk("dir_sel3_done", bus.done, 0);
        bus.sel = 3'd7;
        tick();
        chk("dir_sel7_f", bus.f, 4'hF);
        chk("dir_sel7_fch", bus.f_ch, 7);

        // Direct mode, random data and index; N=5 instance covers out-of-range indices.
        for (int k = 0; k < 16; k++) begin
            wv  = $urandom;
            wv5 = 20'($urandom);
            s   = 3'($urandom);
            s5  = 3'($urandom);
            bus.w         = wv;
            bus.sel       = s;
            bus.out_ready = 1'($urandom);
            bus5.w        = wv5;
            bus5.sel      = s5;
            tick();
            chk("dir_rand_f", bus.f, exp_word(wv, int'(s)));
            chk("dir_rand_fch", bus.f_ch, s);
            chk("dir_rand_fvalid", bus.f_valid, 1);
            chk("dir5_f", bus5.f, (int'(s5) < N5) ? exp_word({12'h0, wv5}, int'(s5)) : 4'h0);
            chk("dir5_fch", bus5.f_ch, s5);
            chk("dir5_fvalid", bus5.f_valid, 1);
        end

        // Scans on the reference pattern.
        bus.w = 32'hFEDC_BA98;
        run_scan(all_ch, 0, 1'b0, "scan_plain");
        run_scan(all_ch, 2, 1'b0, "scan_stall");
        run_scan(all_ch, 0, 1'b1, "scan_disturb");

        // Reset in the middle of a scan.
        bus.mode      = MODE_SCAN;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        guard = 0;
        while (!(bus.f_valid && bus.f_ch == 3'd4) && guard < 20) begin
            tick();
            guard++;
        end
        chk("midrst_reach_ch4", bus.f_ch, 4);
        chk("midrst_reach_f", bus.f, 4'hC);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_f", bus.f, 0);
        chk("midrst_fch", bus.f_ch, 0);
        chk("midrst_fvalid", bus.f_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        run_scan(all_ch, 0, 1'b0, "scan_after_rst");

`ifdef MUX_SCAN_CH_MASK_EN
        run_scan(8'b1010_0101, 0, 1'b0, "mask_a5");
        run_scan(8'b0000_0000, 0, 1'b0, "mask_zero");
        run_scan(8'b1000_0000, 1, 1'b0, "mask_top");
`endif

        // Randomised scans: random data, random backpressure, noise on ignored inputs.
        for (int k = 0; k < 5; k++) begin
            bus.w = $urandom;
`ifdef MUX_SCAN_CH_MASK_EN
            rmsk = N'($urandom);
`else
            rmsk = all_ch;
`endif
            run_scan(rmsk, 1, 1'b1, "scan_rand");
        end

        // Back to direct mode after scanning.
        bus.w    = 32'hFEDC_BA98;
        bus.mode = MODE_DIRECT;
        bus.sel  = 3'd5;
        tick();
        chk("dir_after_scan_f", bus.f, 4'hD);
        chk("dir_after_scan_fvalid", bus.f_valid, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
